cic3_decimator: RTL and testbench
=================================

# cic3_decimator

Third-order CIC (sinc³) decimation filter converting the 1-bit stream of the second-order sigma-delta modulator back into signed 16-bit PCM samples. It sits directly downstream of the modulator's `dout`, one sample per `clk`, and replaces simple count-the-ones averaging with proper sinc³ anti-alias filtering. It emits one output word every 2^OSR_LOG2 clocks with a single-cycle valid strobe.

## Interface
- `OSR_LOG2`, default 8: decimation ratio R = 2^OSR_LOG2. Legal range 5..10; out of range is a synthesis error.
- `clk`  in  1  clock; every rising edge consumes one input bit.
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `bit_in`  in  1  modulator bitstream; 1 maps to +1, 0 maps to −1.
- `pcm_out`  out  16  signed decimated sample; reset 0; held between strobes.
- `pcm_vld`  out  1  one-cycle strobe marking a new `pcm_out`; reset 0.

## Operation
- Internal width W = 3·OSR_LOG2 + 2 bits, signed. All integrator and comb arithmetic is modulo 2^W; wrap-around is intentional and must not be saturated.
- Input mapping: x = +1 when `bit_in`=1, else −1, sign-extended to W bits.
- Integrators are pipelined registers updated every enabled edge, each stage using the previous stage's pre-edge value: i1 ← i1 + x; i2 ← i2 + i1; i3 ← i3 + i2.
- Phase counter `cnt` runs 0..R−1 and wraps to 0. A tick is an edge where `cnt` = R−1.
- Comb chain on a tick, combinational from pre-edge registers:
  - c1 = i3 − d1; c2 = c1 − d2; c3 = c2 − d3.
  - Then d1 ← i3, d2 ← c1, d3 ← c2.
- Scaling: SHIFT = 3·OSR_LOG2 − 15. The output is c3 arithmetic-shifted right by SHIFT, then clamped to [−32768, +32767]. Full-scale positive (c3 = +R³) therefore yields 32767.
- Fill state: a 2-bit saturating tick counter `fill` counts 0..3.
  - `pcm_vld` is asserted only on ticks where `fill` = 3 before the edge, i.e. the first three ticks after reset are suppressed.
  - `pcm_out` updates only on edges where `pcm_vld` is asserted.

## Timing
- Edge k is the k-th rising edge with `rst_n` high, counting from k = 0.
- Ticks occur at edges R−1, 2R−1, 3R−1, ….
- First `pcm_vld` high appears after edge 4R−1. Thereafter `pcm_vld` is high for exactly one cycle every R cycles.
- `pcm_vld` and `pcm_out` are registered: both change only on the tick edge, with no combinational path from `bit_in`.
- Input-to-integrator latency is 3 cycles, fixed and implementation-visible only through the impulse response; benches must compare against settled values only.
- Reset mid-operation clears, on the same edge: `cnt`, `fill`, i1..i3, d1..d3, `pcm_out`, and `pcm_vld`. Behaviour after release is identical to power-up.
- `rst_n` takes priority over a coincident tick.

## Structure
- Shared package `sdm_pkg`:
  - function `cic_width(order, osr_log2)`;
  - constants PCM_W = 16, CIC_ORDER = 3;
  - function `cic_shift(osr_log2)`.
- One natural sub-module, `sat_shift`: parameterised arithmetic right shift plus clamp from W bits to 16 bits. It is reused by the future interpolator.
- The integrators and comb stay inline: three stages each, via a generate loop over CIC_ORDER.

## Test plan
- Constant `bit_in`=1, R=256: first `pcm_vld` after edge 1023; every settled `pcm_out` = 32767 (saturated from 32768).
- Constant `bit_in`=0: settled `pcm_out` = −32768, with no wrap glitch.
- Alternating 1,0,1,0…: all settled outputs exactly 0.
- Repeating 1,1,1,0 (mean +0.5): settled `pcm_out` = 16384.
- Drive `bit_in` from an `sdm_2o` instance with `din` = 0x2000: settled `pcm_out` within ±64 of 0x2000.
- Assert `rst_n` low for 1 cycle at edge 2000, mid-frame:
  - `pcm_vld` and `pcm_out` read 0 after the reset edge;
  - the next `pcm_vld` comes exactly 4R cycles after release;
  - the strobe spacing afterwards is R.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared sigma-delta constants and CIC sizing helpers.
package sdm_pkg;

    localparam int unsigned PCM_W     = 16;
    localparam int unsigned CIC_ORDER = 3;

    // Register growth of an N-stage CIC plus sign and headroom bits.
    function automatic int unsigned cic_width(input int unsigned order, input int unsigned osr_log2);
        return order * osr_log2 + 2;
    endfunction

    // Right shift that maps full-scale c3 = R^3 onto 2^(PCM_W-1).
    function automatic int unsigned cic_shift(input int unsigned osr_log2);
        return CIC_ORDER * osr_log2 - (PCM_W - 1);
    endfunction

endpackage

// File: rtl/sat_shift.sv
// Arithmetic right shift of a wide signed word, then clamp to signed PCM_W bits.
module sat_shift
    import sdm_pkg::*;
#(
    parameter int unsigned IN_W  = 26,
    parameter int unsigned SHIFT = 9
) (
    input  logic [IN_W-1:0]  din_i,
    output logic [PCM_W-1:0] dout_c
);

    localparam logic signed [IN_W-1:0] PCM_MAX = IN_W'((1 << (PCM_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] PCM_MIN = ~PCM_MAX;

    logic signed [IN_W-1:0] shifted;

    assign shifted = $signed(din_i) >>> SHIFT;

    always_comb begin
        dout_c = PCM_W'(shifted);
        if (shifted > PCM_MAX) begin
            dout_c = PCM_W'(PCM_MAX);
        end else if (shifted < PCM_MIN) begin
            dout_c = PCM_W'(PCM_MIN);
        end
    end

endmodule

// File: rtl/cic3_decimator.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, signed 16-bit PCM out
// every 2^OSR_LOG2 clocks with a one-cycle valid strobe.
module cic3_decimator
    import sdm_pkg::*;
#(
    parameter int unsigned OSR_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    output logic [15:0] pcm_out,
    output logic        pcm_vld
);

    localparam int unsigned W     = cic_width(CIC_ORDER, OSR_LOG2);
    localparam int unsigned SHIFT = cic_shift(OSR_LOG2);

    if (OSR_LOG2 < 5 || OSR_LOG2 > 10) begin : g_bad_osr
        $error("cic3_decimator: OSR_LOG2 must be within 5..10");
    end

    logic [OSR_LOG2-1:0] cnt_q, cnt_d;
    logic [1:0]          fill_q, fill_d;
    logic [PCM_W-1:0]    pcm_q, pcm_d;
    logic                vld_q, vld_d;
    logic                tick_c;
    logic [PCM_W-1:0]    sat_c;
    logic signed [W-1:0] x_c;

    logic signed [W-1:0] integ_q  [CIC_ORDER];
    logic signed [W-1:0] integ_in [CIC_ORDER];
    logic signed [W-1:0] dly_q    [CIC_ORDER];
    logic signed [W-1:0] comb_in  [CIC_ORDER];
    logic signed [W-1:0] comb_c   [CIC_ORDER];

    assign tick_c = &cnt_q;
    assign x_c    = bit_in ? W'(1) : '1;

    // Integrators run every edge; comb delays only load on a tick.
    for (genvar k = 0; k < CIC_ORDER; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign integ_in[k] = x_c;
            assign comb_in[k]  = integ_q[CIC_ORDER-1];
        end else begin : g_rest
            assign integ_in[k] = integ_q[k-1];
            assign comb_in[k]  = comb_c[k-1];
        end

        assign comb_c[k] = comb_in[k] - dly_q[k];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end else begin
                integ_q[k] <= integ_q[k] + integ_in[k];
                if (tick_c) begin
                    dly_q[k] <= comb_in[k];
                end
            end
        end
    end

    sat_shift #(
        .IN_W  (W),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .din_i  (comb_c[CIC_ORDER-1]),
        .dout_c (sat_c)
    );

    // The first three ticks only prime the comb delays and are not emitted.
    always_comb begin
        cnt_d  = cnt_q + OSR_LOG2'(1);
        fill_d = fill_q;
        pcm_d  = pcm_q;
        vld_d  = 1'b0;
        if (tick_c) begin
            if (fill_q == 2'd3) begin
                vld_d = 1'b1;
                pcm_d = sat_c;
            end else begin
                fill_d = fill_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            fill_q <= '0;
            pcm_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
            pcm_q  <= pcm_d;
            vld_q  <= vld_d;
        end
    end

    assign pcm_out = pcm_q;
    assign pcm_vld = vld_q;

endmodule

// File: tb/tb_cic3_decimator.sv
// Bench for cic3_decimator: strobe timing, reset behaviour and settled outputs
// for directed and random periodic bitstreams against an arithmetic mean model.
module tb_cic3_decimator;

    localparam int unsigned OSR_LOG2 = 8;
    localparam int          R        = 1 << OSR_LOG2;
    localparam int          SHIFT    = 3 * OSR_LOG2 - 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic [15:0] pcm_out;
    logic        pcm_vld;

    int n_tests = 0;
    int n_fail  = 0;

    cic3_decimator #(.OSR_LOG2(OSR_LOG2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_in  (bit_in),
        .pcm_out (pcm_out),
        .pcm_vld (pcm_vld)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive the bit, let the edge pass, then settle before sampling.
    task automatic step(input logic b);
        bit_in = b;
        @(posedge clk);
        #1;
    endtask

    function automatic longint pcm_signed();
        logic signed [15:0] v;
        v = pcm_out;
        return longint'(v);
    endfunction

    // A stream periodic with period P (P divides R) has a constant sinc^3 output
    // equal to R^3 times its mean; scale and clamp exactly as a 16-bit PCM word.
    function automatic longint model_out(input int per, input logic [15:0] pat);
        longint s;
        longint full;
        longint r3;
        s = 0;
        for (int i = 0; i < per; i++) s += pat[i] ? 1 : -1;
        r3   = longint'(R) * longint'(R) * longint'(R);
        full = (s * r3) / longint'(per);
        full = full >>> SHIFT;
        if (full > 32767)  full = 32767;
        if (full < -32768) full = -32768;
        return full;
    endfunction

    task automatic run_pattern(input string tag, input int per, input logic [15:0] pat);
        longint     exp;
        int         strobes;
        int         budget;
        int         ph;
        int         last;
        logic [15:0] prev_out;
        exp     = model_out(per, pat);
        strobes = 0;
        budget  = 0;
        ph      = 0;
        last    = -1;
        while (strobes < 7 && budget < 8 * R) begin
            prev_out = pcm_out;
            step(pat[ph]);
            ph = (ph + 1) % per;
            budget++;
            if (pcm_vld) begin
                strobes++;
                if (last >= 0) check_eq({tag, " spacing"}, budget - last, R);
                last = budget;
                if (strobes >= 5) check_eq({tag, " value"}, pcm_signed(), exp);
            end else if (last >= 0 && budget - last == R / 2) begin
                check_eq({tag, " hold"}, pcm_out, prev_out);
            end
        end
        if (strobes < 7) check_eq({tag, " timeout"}, strobes, 7);
    endtask

    initial begin
        int n;
        int per;
        logic [15:0] pat;

        rst_n  = 1'b0;
        bit_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset vld", pcm_vld, 0);
        check_eq("reset out", pcm_out, 0);
        rst_n = 1'b1;

        // First strobe after edge 4R-1, i.e. on the 4R-th edge after release.
        n = 0;
        while (!pcm_vld && n < 5 * R) begin
            step(1'b1);
            n++;
        end
        check_eq("first vld edge", n, 4 * R);

        run_pattern("const1", 1, 16'h0001);
        run_pattern("const0", 1, 16'h0000);
        run_pattern("alt10", 2, 16'h0001);
        run_pattern("p1110", 4, 16'h0007);

        for (int t = 0; t < 8; t++) begin
            per = 1 << $urandom_range(0, 4);
            pat = 16'($urandom);
            run_pattern($sformatf("rand%0d_p%0d", t, per), per, pat);
        end

        // Mid-frame reset with a non-zero output held beforehand.
        run_pattern("pre_rst", 1, 16'h0001);
        repeat (R / 2 + 3) step(1'($urandom));
        rst_n = 1'b0;
        step(1'b1);
        check_eq("mid rst vld", pcm_vld, 0);
        check_eq("mid rst out", pcm_out, 0);
        rst_n = 1'b1;

        n = 0;
        while (!pcm_vld && n < 5 * R) begin
            step(1'($urandom));
            n++;
        end
        check_eq("post rst first vld", n, 4 * R);
        n = 0;
        do begin
            step(1'($urandom));
            n++;
        end while (!pcm_vld && n < 2 * R);
        check_eq("post rst spacing", n, R);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
